// File: rtl/ddr_test_seq_if.sv
// AXI burst channels between the DDR self-test sequencer (master) and the memory port (slave).
interface ddr_test_seq_if;
  logic [31:0] AwAddr;
  logic [7:0]  AwLen;
  logic        AwValid;
  logic        AwReady;
  logic        WValid;
  logic        WLast;
  logic        WReady;
  logic        BValid;
  logic        BReady;
  logic [31:0] ArAddr;
  logic [7:0]  ArLen;
  logic        ArValid;
  logic        ArReady;
  logic        RValid;
  logic        RLast;
  logic        RReady;

  modport master (
    output AwAddr, AwLen, AwValid, WValid, WLast, BReady, ArAddr, ArLen, ArValid, RReady,
    input  AwReady, WReady, BValid, ArReady, RValid, RLast
  );
  modport slave (
    input  AwAddr, AwLen, AwValid, WValid, WLast, BReady, ArAddr, ArLen, ArValid, RReady,
    output AwReady, WReady, BValid, ArReady, RValid, RLast
  );
endinterface

// File: rtl/ddr_test_seq.sv
// DDR self-test burst sequencer: writes a region with INCR bursts, reads it back,
// steers the pattern generator / checker, and counts checker errors and rounds.
module ddr_test_seq #(
  parameter int          AXI_DATA_WIDTH = 256,
  parameter int          BURST_LEN      = 16,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter logic [31:0] ADDR_END       = 32'h0010_0000
) (
  input  logic        SysClk,
  input  logic        SysRst,
  input  logic        TestStart,
  input  logic        LoopEn,
  ddr_test_seq_if.master axi,
  output logic        TestBusy,
  output logic        TestDone,
  output logic [31:0] WrAddrOut,
  output logic        WrStartEn,
  output logic        WriteEn,
  output logic [31:0] RdAddrOut,
  output logic        RdDataEn,
  input  logic        RdError,
  output logic [15:0] ErrCnt,
  output logic [15:0] RoundCnt,
  output logic        ProtoErr
);

  localparam int          BPB  = AXI_DATA_WIDTH / 8;
  localparam logic [31:0] BST  = 32'(BURST_LEN * BPB);
  localparam logic [7:0]  LAST = 8'(BURST_LEN - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW   = 3'd1;
  localparam logic [2:0] WR_PREP = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] RD_AR   = 3'd5;
  localparam logic [2:0] RD_DATA = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]  state;
  logic [31:0] BurstAddr;
  logic [7:0]  BeatCnt;
  logic [31:0] BeatAddr;
  logic [31:0] NextBurst;
  logic        lastBeat;
  logic        startAcc;
  logic        wHs;
  logic        rHs;

  assign BeatAddr  = BurstAddr + 32'(BeatCnt) * 32'(BPB);
  assign NextBurst = BurstAddr + BST;
  assign lastBeat  = (BeatCnt == LAST);
  assign startAcc  = TestStart && (state == IDLE || state == DONE);

  // Outputs are decoded from state so everything idles at 0 straight out of reset.
  assign axi.AwLen   = LAST;
  assign axi.ArLen   = LAST;
  assign axi.AwValid = (state == WR_AW);
  assign axi.AwAddr  = axi.AwValid ? BurstAddr : 32'd0;
  assign axi.WValid  = (state == WR_DATA);
  assign axi.WLast   = axi.WValid && lastBeat;
  assign axi.BReady  = (state == WR_RESP);
  assign axi.ArValid = (state == RD_AR);
  assign axi.ArAddr  = axi.ArValid ? BurstAddr : 32'd0;
  assign axi.RReady  = (state == RD_DATA);

  assign wHs       = axi.WValid && axi.WReady;
  assign rHs       = axi.RValid && axi.RReady;
  assign WriteEn   = wHs;
  assign RdDataEn  = rHs;
  assign WrStartEn = (state == WR_PREP);
  assign WrAddrOut = WrStartEn ? BurstAddr : (axi.WValid ? BeatAddr : 32'd0);
  assign RdAddrOut = axi.RReady ? BeatAddr : 32'd0;
  assign TestBusy  = !(state == IDLE || state == DONE);
  assign TestDone  = (state == DONE);

  always_ff @(posedge SysClk or posedge SysRst) begin
    if (SysRst) begin
      state     <= IDLE;
      BurstAddr <= 32'd0;
      BeatCnt   <= 8'd0;
      ErrCnt    <= 16'd0;
      RoundCnt  <= 16'd0;
      ProtoErr  <= 1'b0;
    end else begin
      // Checker errors trail the beats by its pipeline, so count them in every state.
      if (startAcc)
        ErrCnt <= 16'd0;
      else if (RdError && ErrCnt != 16'hFFFF)
        ErrCnt <= ErrCnt + 16'd1;

      case (state)
        IDLE, DONE: if (TestStart) begin
          BurstAddr <= ADDR_BASE;
          ProtoErr  <= 1'b0;
          state     <= WR_AW;
        end
        WR_AW: if (axi.AwReady) state <= WR_PREP;
        WR_PREP: begin
          BeatCnt <= 8'd0;
          state   <= WR_DATA;
        end
        WR_DATA: if (wHs) begin
          BeatCnt <= BeatCnt + 8'd1;
          if (lastBeat) state <= WR_RESP;
        end
        WR_RESP: if (axi.BValid) begin
          if (NextBurst == ADDR_END) begin
            BurstAddr <= ADDR_BASE;
            state     <= RD_AR;
          end else begin
            BurstAddr <= NextBurst;
            state     <= WR_AW;
          end
        end
        RD_AR: if (axi.ArReady) begin
          BeatCnt <= 8'd0;
          state   <= RD_DATA;
        end
        RD_DATA: if (rHs) begin
          if (axi.RLast != lastBeat) ProtoErr <= 1'b1;
          // Burst length is enforced locally; a misplaced RLast only flags ProtoErr.
          if (lastBeat) begin
            if (NextBurst == ADDR_END) begin
              RoundCnt  <= RoundCnt + 16'd1;
              BurstAddr <= ADDR_BASE;
              state     <= LoopEn ? WR_AW : DONE;
            end else begin
              BurstAddr <= NextBurst;
              state     <= RD_AR;
            end
          end else begin
            BeatCnt <= BeatCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_test_seq.sv
// Directed bench for ddr_test_seq: 4-beat bursts over a 0x100 region, with stalls,
// checker errors, early RLast, looping and mid-burst reset.
module tb_ddr_test_seq;
  logic        SysClk = 0;
  logic        SysRst = 1;
  logic        TestStart = 0;
  logic        LoopEn = 0;
  logic [31:0] WrAddrOut, RdAddrOut;
  logic        WrStartEn, WriteEn, RdDataEn, TestBusy, TestDone, ProtoErr;
  logic        RdError = 0;
  logic [15:0] ErrCnt, RoundCnt;

  ddr_test_seq_if axi();

  ddr_test_seq #(
    .AXI_DATA_WIDTH(256), .BURST_LEN(4), .ADDR_BASE(32'h0), .ADDR_END(32'h100)
  ) dut (
    .SysClk(SysClk), .SysRst(SysRst), .TestStart(TestStart), .LoopEn(LoopEn), .axi(axi.master),
    .TestBusy(TestBusy), .TestDone(TestDone), .WrAddrOut(WrAddrOut), .WrStartEn(WrStartEn),
    .WriteEn(WriteEn), .RdAddrOut(RdAddrOut), .RdDataEn(RdDataEn), .RdError(RdError),
    .ErrCnt(ErrCnt), .RoundCnt(RoundCnt), .ProtoErr(ProtoErr)
  );

  always #5 SysClk = ~SysClk;

  int nCmp = 0;
  int nBad = 0;
  int stallEn = 0;
  int injEarly = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Event logs, cleared whenever a start pulse is seen.
  logic [31:0] awQ[$], wsQ[$], wQ[$], wlQ[$], arQ[$], rQ[$];
  int rBeat = 0;
  int stabErr = 0;
  int wDrop = 0;
  logic        pAwV = 0, pAwHs = 0, pArV = 0, pArHs = 0, pWIn = 0;
  logic [31:0] pAwA = 0, pArA = 0;

  always @(negedge SysClk) begin
    if (SysRst) begin
      pAwV = 0; pArV = 0; pWIn = 0;
    end else begin
      if (TestStart) begin
        awQ.delete(); wsQ.delete(); wQ.delete(); wlQ.delete(); arQ.delete(); rQ.delete();
        rBeat = 0;
      end
      if (pAwV && !pAwHs && (!axi.AwValid || axi.AwAddr != pAwA)) stabErr++;
      if (pArV && !pArHs && (!axi.ArValid || axi.ArAddr != pArA)) stabErr++;
      if (pWIn && !axi.WValid) wDrop++;
      if (axi.AwValid && axi.AwReady) awQ.push_back(axi.AwAddr);
      if (axi.ArValid && axi.ArReady) arQ.push_back(axi.ArAddr);
      if (WrStartEn) wsQ.push_back(WrAddrOut);
      if (WriteEn) begin
        wQ.push_back(WrAddrOut);
        if (axi.WLast) wlQ.push_back(WrAddrOut);
      end
      if (RdDataEn) begin
        rQ.push_back(RdAddrOut);
        rBeat++;
      end
      pAwV = axi.AwValid; pAwA = axi.AwAddr; pAwHs = axi.AwValid && axi.AwReady;
      pArV = axi.ArValid; pArA = axi.ArAddr; pArHs = axi.ArValid && axi.ArReady;
      pWIn = axi.WValid && !(axi.WReady && axi.WLast);
    end
  end

  // Slave side: ready/valid either tied high or randomly stalled; RLast from the beat index.
  initial begin
    axi.AwReady = 1; axi.WReady = 1; axi.BValid = 1; axi.ArReady = 1;
    axi.RValid = 1; axi.RLast = 0;
    forever begin
      @(posedge SysClk); #1;
      if (stallEn != 0) begin
        axi.AwReady = 1'($urandom_range(0, 1));
        axi.WReady  = 1'($urandom_range(0, 1));
        axi.ArReady = 1'($urandom_range(0, 1));
        axi.RValid  = 1'($urandom_range(0, 1));
      end else begin
        axi.AwReady = 1; axi.WReady = 1; axi.ArReady = 1; axi.RValid = 1;
      end
      axi.RLast = ((rBeat % 4) == 3) || (injEarly != 0 && rBeat == 2);
    end
  end

  logic [31:0] expBeat [8] = '{32'h00, 32'h20, 32'h40, 32'h60, 32'h80, 32'hA0, 32'hC0, 32'hE0};
  logic [31:0] expBurst[2] = '{32'h00, 32'h80};
  logic [31:0] expLast [2] = '{32'h60, 32'hE0};

  task automatic startTest();
    @(posedge SysClk); #1 TestStart = 1;
    @(posedge SysClk); #1 TestStart = 0;
    #1;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge SysClk); #2;
      if (TestDone) break;
      n++;
    end
    chk({tag, "/done"}, 32'(TestDone), 32'd1);
  endtask

  task automatic checkRun(input string run);
    chk({run, "/awN"}, 32'(awQ.size()), 32'd2);
    chk({run, "/wsN"}, 32'(wsQ.size()), 32'd2);
    chk({run, "/arN"}, 32'(arQ.size()), 32'd2);
    chk({run, "/wN"},  32'(wQ.size()),  32'd8);
    chk({run, "/wlN"}, 32'(wlQ.size()), 32'd2);
    chk({run, "/rN"},  32'(rQ.size()),  32'd8);
    for (int i = 0; i < 2; i++) begin
      if (i < awQ.size()) chk({run, "/aw"}, awQ[i], expBurst[i]);
      if (i < wsQ.size()) chk({run, "/ws"}, wsQ[i], expBurst[i]);
      if (i < arQ.size()) chk({run, "/ar"}, arQ[i], expBurst[i]);
      if (i < wlQ.size()) chk({run, "/wlast"}, wlQ[i], expLast[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < wQ.size()) chk({run, "/wbeat"}, wQ[i], expBeat[i]);
      if (i < rQ.size()) chk({run, "/rbeat"}, rQ[i], expBeat[i]);
    end
    chk({run, "/stable"}, 32'(stabErr), 32'd0);
    chk({run, "/wdrop"}, 32'(wDrop), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst/busy", 32'(TestBusy), 32'd0);
    chk("rst/done", 32'(TestDone), 32'd0);
    chk("rst/awv", 32'(axi.AwValid), 32'd0);
    chk("rst/awlen", 32'(axi.AwLen), 32'd3);
    chk("rst/arlen", 32'(axi.ArLen), 32'd3);
    chk("rst/err", 32'(ErrCnt), 32'd0);
    chk("rst/round", 32'(RoundCnt), 32'd0);
    @(posedge SysClk); #1 SysRst = 0;

    // Run 1: no stalls.
    startTest();
    waitDone("r1", 200);
    checkRun("r1");
    chk("r1/round", 32'(RoundCnt), 32'd1);
    chk("r1/proto", 32'(ProtoErr), 32'd0);
    chk("r1/err", 32'(ErrCnt), 32'd0);

    // Run 2: random stalls plus three checker error pulses during the read pass.
    stallEn = 1;
    startTest();
    fork
      waitDone("r2", 2000);
      begin
        int n = 0;
        while (n < 2000 && !axi.ArValid) begin
          @(posedge SysClk); #2; n++;
        end
        chk("r2/sawAr", 32'(axi.ArValid), 32'd1);
        repeat (3) begin
          @(posedge SysClk); #1 RdError = 1;
          @(posedge SysClk); #1 RdError = 0;
        end
      end
    join
    stallEn = 0;
    checkRun("r2");
    chk("r2/err", 32'(ErrCnt), 32'd3);
    chk("r2/round", 32'(RoundCnt), 32'd2);

    // Run 3: RLast on beat 2 of the first read burst.
    injEarly = 1;
    startTest();
    chk("r3/errClr", 32'(ErrCnt), 32'd0);
    waitDone("r3", 200);
    injEarly = 0;
    chk("r3/proto", 32'(ProtoErr), 32'd1);
    chk("r3/rN", 32'(rQ.size()), 32'd8);
    chk("r3/arN", 32'(arQ.size()), 32'd2);
    if (arQ.size() > 1) chk("r3/ar1", arQ[1], 32'h80);
    if (rQ.size() > 4) chk("r3/rbeat4", rQ[4], 32'h80);
    chk("r3/round", 32'(RoundCnt), 32'd3);

    // ErrCnt saturation.
    @(posedge SysClk); #1 RdError = 1;
    repeat (70000) @(posedge SysClk);
    #1 RdError = 0;
    #1 chk("sat/err", 32'(ErrCnt), 32'hFFFF);
    chk("sat/proto", 32'(ProtoErr), 32'd1);

    // Looping rounds, then drop LoopEn.
    LoopEn = 1;
    startTest();
    chk("loop/errClr", 32'(ErrCnt), 32'd0);
    chk("loop/protoClr", 32'(ProtoErr), 32'd0);
    begin
      int n = 0;
      while (n < 1000 && RoundCnt != 16'd5) begin
        @(posedge SysClk); #2; n++;
      end
    end
    chk("loop/round5", 32'(RoundCnt), 32'd5);
    chk("loop/busy", 32'(TestBusy), 32'd1);
    LoopEn = 0;
    waitDone("loop", 400);
    chk("loop/round6", 32'(RoundCnt), 32'd6);
    chk("loop/awN", 32'(awQ.size()), 32'd6);
    if (awQ.size() > 5) begin
      chk("loop/aw2", awQ[2], 32'h00);
      chk("loop/aw4", awQ[4], 32'h00);
      chk("loop/aw5", awQ[5], 32'h80);
    end

    // Reset in the middle of a write burst.
    startTest();
    begin
      int n = 0;
      while (n < 200 && !axi.WValid) begin
        @(posedge SysClk); #2; n++;
      end
    end
    chk("mid/wvalid", 32'(axi.WValid), 32'd1);
    #1 SysRst = 1;
    #1;
    chk("mid/wvalid0", 32'(axi.WValid), 32'd0);
    chk("mid/wraddr0", WrAddrOut, 32'd0);
    chk("mid/busy0", 32'(TestBusy), 32'd0);
    chk("mid/round0", 32'(RoundCnt), 32'd0);
    @(posedge SysClk); #1 SysRst = 0;
    startTest();
    waitDone("rst2", 200);
    checkRun("rst2");
    chk("rst2/round", 32'(RoundCnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/ddr_test_seq.md
Name: ddr_test_seq

Overview:
- AXI burst sequencer for the DDR self-test datapath.
- Write pass: sweeps a fixed address region with INCR write bursts. Drives the write-data generator's address/start/enable inputs so the generated pattern is valid on the W channel.
- Read pass: reads the same region back. Drives the read checker's address and data-valid inputs in lockstep with R beats.
- Counts checker errors and completed rounds.

Parameters:
AXI_DATA_WIDTH, 256, data bus width; bytes per beat BPB = AXI_DATA_WIDTH/8
BURST_LEN, 16, beats per burst (1..256); burst stride BST = BURST_LEN*BPB
ADDR_BASE, 32'h0000_0000, first burst address, BST-aligned
ADDR_END, 32'h0010_0000, exclusive end address; (ADDR_END-ADDR_BASE) is a nonzero multiple of BST

Ports:
SysClk  in  1  system clock
SysRst  in  1  asynchronous reset, active-high
TestStart  in  1  pulse: start test; ignored unless state IDLE or DONE
LoopEn  in  1  sampled at end of read pass: 1 = start a new round
TestBusy  out  1  high in any state except IDLE/DONE
TestDone  out  1  high in DONE
AwAddr  out  32  write burst address
AwLen  out  8  BURST_LEN-1, constant
AwValid  out  1  write address valid
AwReady  in  1  write address ready
WValid  out  1  write data valid (data supplied by generator)
WLast  out  1  last beat of write burst
WReady  in  1  write data ready
BValid  in  1  write response valid
BReady  out  1  write response ready
ArAddr  out  32  read burst address
ArLen  out  8  BURST_LEN-1, constant
ArValid  out  1  read address valid
ArReady  in  1  read address ready
RValid  in  1  read data valid
RLast  in  1  read last
RReady  out  1  read data ready
WrAddrOut  out  32  beat address to generator WrAddrIn
WrStartEn  out  1  generator load pulse
WriteEn  out  1  generator advance (= W handshake)
RdAddrOut  out  32  expected beat address to checker RdAddrIn
RdDataEn  out  1  checker data valid (= R handshake)
RdError  in  1  checker per-beat error pulse
ErrCnt  out  16  saturating count of RdError pulses
RoundCnt  out  16  completed read passes, wraps at 16'hFFFF->0
ProtoErr  out  1  sticky: RLast placement mismatch

Behaviour:
- Reset: async, state IDLE. All outputs 0, except AwLen/ArLen, which are constant BURST_LEN-1. Counters, beat counter and address registers cleared. Reset mid-burst aborts the burst with no further handshakes.
- Registers: BurstAddr (32b), BeatCnt (8b).
- States: IDLE, WR_AW, WR_PREP, WR_DATA, WR_RESP, RD_AR, RD_DATA, DONE.
- IDLE/DONE + TestStart:
  - BurstAddr=ADDR_BASE.
  - Clear ErrCnt and ProtoErr; RoundCnt is not cleared.
  - Next state WR_AW.
- WR_AW:
  - AwValid=1, AwAddr=BurstAddr.
  - AwValid stays high and AwAddr stays stable until AwReady.
  - On handshake -> WR_PREP.
- WR_PREP (exactly 1 cycle):
  - WrStartEn=1, WrAddrOut=BurstAddr, BeatCnt=0.
  - Next state WR_DATA. The generator output holds beat-0 data on entry.
- WR_DATA:
  - WValid=1; WrAddrOut=BurstAddr+BeatCnt*BPB (32b, mod 2^32).
  - WLast=(BeatCnt==BURST_LEN-1).
  - WriteEn=WValid&WReady.
  - On handshake BeatCnt++. On the WLast handshake -> WR_RESP.
  - WValid never drops mid-burst.
- WR_RESP:
  - BReady=1.
  - On BValid: BurstAddr+=BST.
  - If the new BurstAddr==ADDR_END: BurstAddr=ADDR_BASE -> RD_AR. Otherwise -> WR_AW.
  - BResp is not checked.
- RD_AR:
  - ArValid=1, ArAddr=BurstAddr, held until ArReady.
  - On handshake: BeatCnt=0 -> RD_DATA.
- RD_DATA:
  - RReady=1; RdAddrOut=BurstAddr+BeatCnt*BPB (combinational, same cycle as the R beat).
  - RdDataEn=RValid&RReady.
  - ProtoErr is set if RLast!=(BeatCnt==BURST_LEN-1) on any R handshake.
  - On a handshake with BeatCnt==BURST_LEN-1, the burst ends regardless of RLast:
    - BurstAddr+=BST.
    - If the new BurstAddr==ADDR_END: RoundCnt++ and BurstAddr=ADDR_BASE, then -> WR_AW if LoopEn else DONE.
    - Otherwise -> RD_AR.
- ErrCnt:
  - +1 on each RdError cycle in any state, saturating at 16'hFFFF.
  - RdError is counted even though it arrives ~2 cycles after the beat (checker pipeline) and may land after the state has left RD_DATA.
- Outstanding transactions: at most one at any time; AW/W and AR are never concurrent.
- Simultaneous TestStart and reset: reset wins.
- TestStart is ignored while busy.

Test Plan:
- BURST_LEN=4, BPB=32, region 0..0x100, AwReady/WReady/BValid tied 1 -> 2 write bursts at AwAddr 0x00 and 0x80. WrStartEn with WrAddrOut=0x00, then beats with WrAddrOut 0x00, 0x20, 0x40, 0x60 and WLast on 0x60. Then 2 reads at 0x00 and 0x80; TestDone=1, RoundCnt=1.
- Random AwReady/WReady/ArReady/RValid stalls -> AwAddr/ArAddr stable while valid is high; WValid does not drop mid-burst; beat addresses identical to the no-stall run.
- RdError pulsed 3 times during read -> ErrCnt=3. Force 70000 pulses -> ErrCnt holds 16'hFFFF.
- RLast asserted on beat 2 of 4 -> ProtoErr=1 and sticky; burst still ends after beat 3.
- LoopEn=1 -> after the read pass, AwAddr=ADDR_BASE again and RoundCnt increments each pass. Drop LoopEn -> DONE after the current read pass.
- SysRst asserted mid WR_DATA -> all outputs 0 at once. Next TestStart restarts at ADDR_BASE with WrStartEn.
